// File: rtl/imem_loader.sv
// Byte-stream loaded instruction memory: receives a little-endian word-count header
// and payload words, holds the core in reset until loaded, then serves fetches.
module imem_loader #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  reload,
    input  logic [31:0]           pc_if,
    output logic [31:0]           instruction_if,
    output logic                  core_rstn,
    output logic                  load_done,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic                  err_overflow
);

    localparam int                DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [31:0]       DEPTH_W = 32'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_byte_cnt, w_byte_cnt_nxt;
    logic [23:0]           r_shift, w_shift_nxt;
    logic [31:0]           r_n, w_n_nxt;
    logic [31:0]           r_word_idx, w_word_idx_nxt;
    logic [DEPTH_LOG2:0]   r_word_count, w_word_count_nxt;
    logic                  r_rx_ready, w_rx_ready_nxt;
    logic                  r_load_done, w_load_done_nxt;
    logic                  r_core_rstn, w_core_rstn_nxt;
    logic                  r_err_ovf, w_err_ovf_nxt;

    logic                  w_xfer;
    logic                  w_reload;
    logic                  w_we;
    logic [31:0]           w_wdata;
    logic [31:0]           w_hdr_n;
    logic [DEPTH_LOG2-1:0] w_fidx;
    logic                  w_hit;

    logic [31:0]           r_mem [DEPTH];

    assign w_xfer   = rx_valid && r_rx_ready;
    assign w_reload = reload && (r_state != S_IDLE);
    assign w_wdata  = {rx_data, r_shift};
    assign w_hdr_n  = {rx_data, r_shift};

    // Next-state and next-output logic; reload outranks any byte in the same cycle
    always_comb begin
        w_state_nxt      = r_state;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_shift_nxt      = r_shift;
        w_n_nxt          = r_n;
        w_word_idx_nxt   = r_word_idx;
        w_word_count_nxt = r_word_count;
        w_load_done_nxt  = r_load_done;
        w_core_rstn_nxt  = r_core_rstn;
        w_err_ovf_nxt    = r_err_ovf;
        w_we             = 1'b0;

        if (w_reload) begin
            w_state_nxt      = S_HDR;
            w_byte_cnt_nxt   = 2'd0;
            w_word_idx_nxt   = 32'd0;
            w_word_count_nxt = '0;
            w_load_done_nxt  = 1'b0;
            w_core_rstn_nxt  = 1'b0;
            w_err_ovf_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt      = S_HDR;
                    w_byte_cnt_nxt   = 2'd0;
                    w_word_count_nxt = '0;
                end
                S_HDR, S_DATA: begin
                    if (w_xfer) begin
                        case (r_byte_cnt)
                            2'd0:    w_shift_nxt[7:0]   = rx_data;
                            2'd1:    w_shift_nxt[15:8]  = rx_data;
                            2'd2:    w_shift_nxt[23:16] = rx_data;
                            default: w_shift_nxt        = r_shift;
                        endcase
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_state == S_HDR) begin
                                w_n_nxt        = w_hdr_n;
                                w_word_idx_nxt = 32'd0;
                                if (w_hdr_n == 32'd0) begin
                                    w_state_nxt     = S_DONE;
                                    w_load_done_nxt = 1'b1;
                                    w_core_rstn_nxt = 1'b1;
                                end else begin
                                    w_state_nxt   = S_DATA;
                                    w_err_ovf_nxt = (w_hdr_n > DEPTH_W);
                                end
                            end else begin
                                // Words past the end of the RAM are consumed but not stored
                                if (r_word_idx < DEPTH_W) begin
                                    w_we             = 1'b1;
                                    w_word_count_nxt = r_word_count + CNT_ONE;
                                end else begin
                                    w_we = 1'b0;
                                end
                                w_word_idx_nxt = r_word_idx + 32'd1;
                                if (r_word_idx == (r_n - 32'd1)) begin
                                    w_state_nxt     = S_DONE;
                                    w_load_done_nxt = 1'b1;
                                    w_core_rstn_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = r_state;
                                end
                            end
                        end else begin
                            w_state_nxt = r_state;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_rx_ready_nxt = ((w_state_nxt == S_HDR) || (w_state_nxt == S_DATA)) && !w_reload;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'd0;
            r_n          <= 32'd0;
            r_word_idx   <= 32'd0;
            r_word_count <= '0;
            r_rx_ready   <= 1'b0;
            r_load_done  <= 1'b0;
            r_core_rstn  <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_n          <= w_n_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_word_count <= w_word_count_nxt;
            r_rx_ready   <= w_rx_ready_nxt;
            r_load_done  <= w_load_done_nxt;
            r_core_rstn  <= w_core_rstn_nxt;
            r_err_ovf    <= w_err_ovf_nxt;
        end
    end

    // Program RAM; never cleared, stale words are masked by the word_count bound
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_word_idx[DEPTH_LOG2-1:0]] <= w_wdata;
        end
    end

    assign w_fidx = pc_if[DEPTH_LOG2+1:2];
    assign w_hit  = r_load_done && (pc_if[1:0] == 2'b00) &&
                    ((pc_if >> (DEPTH_LOG2 + 2)) == 32'd0) &&
                    ({1'b0, w_fidx} < r_word_count);

    // Zero-latency fetch port
    always_comb begin
        if (w_hit) begin
            instruction_if = r_mem[w_fidx];
        end else begin
            instruction_if = 32'h0;
        end
    end

    assign rx_ready     = r_rx_ready;
    assign core_rstn    = r_core_rstn;
    assign load_done    = r_load_done;
    assign word_count   = r_word_count;
    assign err_overflow = r_err_ovf;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 256-word and a 4-word instance share one byte stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        reload = 1'b0;
    logic [31:0] pc_if = 32'h0;

    logic        rdy_a, crst_a, done_a, ovf_a;
    logic [31:0] ins_a;
    logic [8:0]  wc_a;
    logic        rdy_b, crst_b, done_b, ovf_b;
    logic [31:0] ins_b;
    logic [2:0]  wc_b;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;
    int first_acc = 0;
    int last_acc = 0;
    bit tog = 1'b0;

    imem_loader #(.DEPTH_LOG2(8)) dut_a (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy_a), .reload(reload), .pc_if(pc_if), .instruction_if(ins_a),
        .core_rstn(crst_a), .load_done(done_a), .word_count(wc_a), .err_overflow(ovf_a)
    );

    imem_loader #(.DEPTH_LOG2(2)) dut_b (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy_b), .reload(reload), .pc_if(pc_if), .instruction_if(ins_b),
        .core_rstn(crst_b), .load_done(done_b), .word_count(wc_b), .err_overflow(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (tog) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rdy_a !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", {31'd0, rdy_a}, 32'd1);
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) send_byte(t[8*i +: 8]);
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic fetch_a(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        pc_if = pc;
        #1;
        chk(tag, ins_a, exp);
    endtask

    task automatic do_reload(input bit with_byte);
        @(negedge clk);
        reload   = 1'b1;
        rx_valid = with_byte;
        rx_data  = 8'hFF;
        @(posedge clk);
        #1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        chk("rld_rdy_low", {31'd0, rdy_a}, 32'd0);
        chk("rld_crst_low", {31'd0, crst_a}, 32'd0);
        chk("rld_done_low", {31'd0, done_a}, 32'd0);
        @(posedge clk);
        #1;
        chk("rld_rdy_high", {31'd0, rdy_a}, 32'd1);
    endtask

    // Three-instruction program used by the first two loads
    task automatic send_prog3();
        send_word(32'd3);
        send_byte(8'h93);
        first_acc = last_acc - 4;
        first_acc = first_acc;
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_word(32'h00100113);
        send_word(32'h00200213);
        idle();
    endtask

    task automatic check_prog3(input string tag, input int span);
        chk({tag, "_done"}, {31'd0, done_a}, 32'd1);
        chk({tag, "_crst"}, {31'd0, crst_a}, 32'd1);
        chk({tag, "_wc"}, 32'(wc_a), 32'd3);
        chk({tag, "_rdy"}, {31'd0, rdy_a}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf_a}, 32'd0);
        chk({tag, "_span"}, 32'(last_acc - first_acc + 1), 32'(span));
        fetch_a({tag, "_pc0"}, 32'd0, 32'h00100093);
        fetch_a({tag, "_pc4"}, 32'd4, 32'h00100113);
        fetch_a({tag, "_pc8"}, 32'd8, 32'h00200213);
        fetch_a({tag, "_pc12"}, 32'd12, 32'h0);
        fetch_a({tag, "_pc2"}, 32'd2, 32'h0);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_rdy", {31'd0, rdy_a}, 32'd0);
        chk("rst_crst", {31'd0, crst_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_wc", 32'(wc_a), 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        chk("rst_ins", ins_a, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_rdy", {31'd0, rdy_a}, 32'd1);

        // N=3, back-to-back bytes; first accept is the first header byte
        send_byte(8'h03);
        first_acc = last_acc;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h00100093);
        send_word(32'h00100113);
        send_byte(8'h13); send_byte(8'h02); send_byte(8'h20);
        chk("pre_last_crst", {31'd0, crst_a}, 32'd0);
        send_byte(8'h00);
        idle();
        check_prog3("full", 16);

        // Same stream, rx_valid toggling every cycle
        do_reload(1'b0);
        chk("rld_wc_clr", 32'(wc_a), 32'd0);
        fetch_a("rld_pc0", 32'd0, 32'h0);
        tog = 1'b1;
        send_byte(8'h03);
        first_acc = last_acc;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h00100093);
        send_word(32'h00100113);
        send_word(32'h00200213);
        idle();
        tog = 1'b0;
        check_prog3("tog", 31);

        // Empty program
        do_reload(1'b0);
        send_word(32'd0);
        idle();
        chk("n0_done", {31'd0, done_a}, 32'd1);
        chk("n0_crst", {31'd0, crst_a}, 32'd1);
        chk("n0_wc", 32'(wc_a), 32'd0);
        @(posedge clk);
        #1;
        chk("n0_rdy", {31'd0, rdy_a}, 32'd0);
        fetch_a("n0_pc0", 32'd0, 32'h0);
        fetch_a("n0_pc4", 32'd4, 32'h0);

        // Overflow on the 4-word instance
        do_reload(1'b0);
        send_word(32'd6);
        chk("ovf_b_set", {31'd0, ovf_b}, 32'd1);
        chk("ovf_a_clr", {31'd0, ovf_a}, 32'd0);
        for (int k = 0; k < 5; k++) send_word(32'hA0000000 + 32'(k));
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        chk("ovf_pre_done", {31'd0, done_b}, 32'd0);
        send_byte(8'hA0);
        idle();
        chk("ovf_done", {31'd0, done_b}, 32'd1);
        chk("ovf_wc_b", 32'(wc_b), 32'd4);
        chk("ovf_wc_a", 32'(wc_a), 32'd6);
        pc_if = 32'd12;
        #1;
        chk("ovf_pc12", ins_b, 32'hA0000003);
        pc_if = 32'd16;
        #1;
        chk("ovf_pc16", ins_b, 32'h0);

        // Reload mid-payload, with a byte offered in the reload cycle
        do_reload(1'b0);
        send_word(32'd3);
        send_word(32'h11111111);
        send_word(32'h22222222);
        do_reload(1'b1);
        send_word(32'd1);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD);
        chk("rl_pre_crst", {31'd0, crst_a}, 32'd0);
        send_byte(8'hDE);
        idle();
        chk("rl_crst", {31'd0, crst_a}, 32'd1);
        chk("rl_wc", 32'(wc_a), 32'd1);
        fetch_a("rl_pc0", 32'd0, 32'hDEADBEEF);
        fetch_a("rl_pc4", 32'd4, 32'h0);

        // Asynchronous reset mid-header
        do_reload(1'b0);
        send_byte(8'h01);
        send_byte(8'h00);
        #1;
        rstn = 1'b0;
        #1;
        chk("ar1_rdy", {31'd0, rdy_a}, 32'd0);
        chk("ar1_done", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'd1);
        send_word(32'h12345678);
        idle();
        fetch_a("ar1_pc0", 32'd0, 32'h12345678);

        // Asynchronous reset in DONE
        pc_if = 32'd0;
        #1;
        rstn = 1'b0;
        #1;
        chk("ar2_done", {31'd0, done_a}, 32'd0);
        chk("ar2_crst", {31'd0, crst_a}, 32'd0);
        chk("ar2_wc", 32'(wc_a), 32'd0);
        chk("ar2_ins", ins_a, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'd2);
        send_word(32'hCAFEF00D);
        send_word(32'h0BADC0DE);
        idle();
        chk("ar2_wc_after", 32'(wc_a), 32'd2);
        chk("ar2_crst_after", {31'd0, crst_a}, 32'd1);
        fetch_a("ar2_pc4", 32'd4, 32'h0BADC0DE);
        fetch_a("ar2_pc8", 32'd8, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised, byte-stream-loaded instruction memory for the pipelined core. It replaces the fixed 32-word hard-wired instruction bus with a `2**DEPTH_LOG2`-word RAM. The RAM is filled through a valid/ready byte handshake (UART receiver or testbench). The block holds the core in reset until a complete program has been received and serves instruction fetches to the IF stage once loading is done.

## Interface
Parameters:
- `DEPTH_LOG2`, 8, log2 of memory depth in 32-bit words (DEPTH = 2**DEPTH_LOG2).

Ports:
- `clk`, in, 1, sole clock; all state updates on rising edge.
- `rstn`, in, 1, one clock; reset is asynchronous and active-low.
- `rx_valid`, in, 1, `rx_data` holds a valid byte.
- `rx_data`, in, 8, load stream byte.
- `rx_ready`, out, 1, block accepts a byte this cycle.
- `reload`, in, 1, single-cycle request to restart loading.
- `pc_if`, in, 32, byte address of the fetch from the core IF stage.
- `instruction_if`, out, 32, fetched instruction word.
- `core_rstn`, out, 1, active-low reset to the core; high only when loaded.
- `load_done`, out, 1, program completely received.
- `word_count`, out, DEPTH_LOG2+1, number of words stored by the current or last load.
- `err_overflow`, out, 1, header count exceeded DEPTH.

## Operation
- States: IDLE (reset state), HDR, DATA, DONE.
  - IDLE → HDR unconditionally on the next edge.
  - HDR → DATA after the 4th header byte, or HDR → DONE if the header count N = 0.
  - DATA → DONE on the final byte, i.e. byte 4·N of the payload.
  - `reload`=1 in any state except IDLE → HDR.
- Byte transfer occurs on a rising edge with `rx_valid && rx_ready`. No transfer means no state or counter change.
- `rx_ready` is registered: 1 in HDR/DATA, 0 in IDLE/DONE, and 0 in the cycle following `reload`.
- Header format: 4 bytes, little-endian 32-bit word count N. Payload format: N words, each 4 bytes little-endian. Word i is written to address i.
- Overflow: if N > DEPTH, `err_overflow` is set when the header completes. Words with index ≥ DEPTH are accepted and discarded, and the load still completes after 4·N payload bytes.
- `word_count` counts written words, saturating at DEPTH. It is cleared on entry to HDR.
- Fetch read is combinational. `instruction_if` returns:
  - the stored word at index `pc_if[DEPTH_LOG2+1:2]`, when `load_done`=1, `pc_if[1:0]`=0, `pc_if[31:DEPTH_LOG2+2]`=0 and index < `word_count`;
  - 32'h0 otherwise.
- RAM contents are not cleared by reset or reload. The `word_count` bound hides stale data.
- `reload` has priority over a byte transfer in the same cycle; that byte is dropped. `reload` in IDLE is ignored.

## Timing
- Reset values: `rx_ready`=0, `core_rstn`=0, `load_done`=0, `word_count`=0, `err_overflow`=0, `instruction_if`=0. State = IDLE.
- First edge after `rstn` deasserts: state HDR and `rx_ready`=1. Byte acceptance is possible from the second edge.
- On the edge that accepts the final payload byte (edge T):
  - the word is written;
  - `word_count` is incremented;
  - state goes to DONE;
  - `load_done`=1 and `core_rstn`=1 are registered on the same edge T.
  - After T the fetch returns the new data with zero latency.
- For N=0, `load_done`/`core_rstn` rise on the edge that accepts header byte 4.
- `reload` accepted at edge T: `core_rstn`, `load_done` and `err_overflow` are 0 after T, and `rx_ready`=0 after T. `rx_ready`=1 after T+1.
- `rstn` low at any time, including mid-word: all outputs immediately return to reset values, and any partial byte assembly is discarded.
- Sustained throughput: one byte per cycle.

## Test plan
- DEPTH_LOG2=8, stream N=3 then words 0x00100093, 0x00100113, 0x00200213 with `rx_valid` held high → done 16 cycles after the first accept, `word_count`=3, `core_rstn`=1; `pc_if`=4 → 0x00100113, `pc_if`=12 → 0, `pc_if`=2 → 0.
- Same stream with `rx_valid` toggling 1/0 every cycle → identical final state; no progress in idle cycles; done after 31 cycles.
- Header N=0 → `load_done`=1 after the 4th byte, `rx_ready`=0 afterwards, all fetches return 0.
- DEPTH_LOG2=2, N=6 → `err_overflow`=1, 24 payload bytes consumed, `word_count`=4; `pc_if`=12 → word 3, `pc_if`=16 → 0.
- `reload` after 2 payload words of N=3, then a new stream with N=1 and word 0xDEADBEEF → `core_rstn` stays 0 until the new load finishes; then `word_count`=1, `pc_if`=0 → 0xDEADBEEF, `pc_if`=4 → 0.
- `rstn` pulsed low mid-header and in DONE → all outputs 0 asynchronously; a full reload afterwards succeeds.
